// File: rtl/lnrv_plic_gateway.sv
// Interrupt gateway in front of lnrv_plic. Each source is synchronised and turned into a
// level or rising-edge request, then held until the PLIC claims and completes it.
module lnrv_plic_gateway #(
    parameter int P_IRQ_COUNT   = 32,
    parameter int P_SYNC_STAGES = 2,
    parameter int P_EDGE_CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P_IRQ_COUNT-1:0] src_irq,
    input  logic [P_IRQ_COUNT-1:0] cfg_edge,
    input  logic                   claim_vld,
    input  logic [9:0]             claim_id,
    input  logic                   cmpl_vld,
    input  logic [9:0]             cmpl_id,
    input  logic [P_IRQ_COUNT-1:0] ovf_clr,
    output logic [P_IRQ_COUNT-1:0] irq,
    output logic [P_IRQ_COUNT-1:0] ovf
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [P_EDGE_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [P_EDGE_CNT_W-1:0] CNT_ONE = P_EDGE_CNT_W'(1);

    logic [P_IRQ_COUNT-1:0] sync_q [P_SYNC_STAGES];
    logic [P_IRQ_COUNT-1:0] s;
    logic [P_IRQ_COUNT-1:0] p_q;
    logic [P_IRQ_COUNT-1:0] e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < P_SYNC_STAGES; k++) sync_q[k] <= '0;
            p_q <= '0;
        end else begin
            sync_q[0] <= src_irq;
            for (int k = 1; k < P_SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            p_q <= s;
        end
    end

    assign s = sync_q[P_SYNC_STAGES-1];
    assign e = s & ~p_q;

    for (genvar gi = 0; gi < P_IRQ_COUNT; gi++) begin : g_src
        localparam logic [9:0] SRC_ID = 10'(gi + 1);

        state_t                  state_q, state_d;
        logic [P_EDGE_CNT_W-1:0] cnt_q, cnt_d;
        logic [P_EDGE_CNT_W:0]   cnt_sum;
        logic                    ovf_q, ovf_d;
        logic                    cfg_q;
        logic                    hit_claim, hit_cmpl, done;

        assign hit_claim = claim_vld && (claim_id == SRC_ID);
        assign hit_cmpl  = cmpl_vld && (cmpl_id == SRC_ID);
        assign done      = hit_cmpl && (state_q == ST_ACTIVE);
        // An edge arriving in the completion cycle is folded into the re-arm decision.
        assign cnt_sum   = {1'b0, cnt_q} + {{P_EDGE_CNT_W{1'b0}}, e[gi]};

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ovf_d   = ovf_q & ~ovf_clr[gi];
            case (state_q)
                ST_IDLE: begin
                    if (cfg_edge[gi] ? e[gi] : s[gi]) state_d = ST_PEND;
                end
                ST_PEND: begin
                    if (hit_claim) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (hit_cmpl) begin
                        if (cfg_edge[gi]) begin
                            if (cnt_sum != '0) begin
                                state_d = ST_PEND;
                                cnt_d   = cnt_sum[P_EDGE_CNT_W-1:0] - CNT_ONE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            state_d = s[gi] ? ST_PEND : ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (cfg_edge[gi] && !done && (state_q != ST_IDLE) && e[gi]) begin
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + CNT_ONE;
            end
            if (!cfg_edge[gi] || (cfg_edge[gi] != cfg_q)) cnt_d = '0;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                cfg_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
                cfg_q   <= cfg_edge[gi];
            end
        end

        assign irq[gi] = (state_q == ST_PEND);
        assign ovf[gi] = ovf_q;
    end

endmodule
